// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets N_REQ requesters share one uart_tx.
// Each grant carries one byte, and a stalled uart_tx is aborted after TIMEOUT_CYCLES.
module uart_tx_arbiter #(
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_REQ-1:0]              req,
  input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]              ack,
  output logic [N_REQ-1:0]              grant,
  output logic                          busy,
  output logic                          timeout_err,
  output logic                          tx_start,
  output logic [DATA_WIDTH-1:0]         tx_din,
  input  logic                          tx_done_tick
);

  localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, ACK} state_t;

  state_t                  state_q, state_d;
  logic [PW-1:0]           rr_q, rr_d;
  logic [PW-1:0]           idx_q, idx_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    abort_q, abort_d;
  logic [N_REQ-1:0]        grant_d;
  logic [DATA_WIDTH-1:0]   din_d;

  logic                    hit;
  int unsigned             arb_j;
  logic [N_REQ-1:0]        req_sh;
  logic [PW-1:0]           win_idx;
  logic [N_REQ-1:0]        win_oh;
  logic [DATA_WIDTH-1:0]   win_data;

  // Search upward from rr_q with wraparound; first set request wins.
  always_comb begin
    hit      = 1'b0;
    arb_j    = 0;
    req_sh   = '0;
    win_idx  = '0;
    win_oh   = '0;
    win_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      arb_j = 32'(rr_q) + i;
      if (arb_j >= N_REQ) arb_j = arb_j - N_REQ;
      req_sh = req >> arb_j;
      if (!hit && req_sh[0]) begin
        hit      = 1'b1;
        win_idx  = PW'(arb_j);
        win_oh   = N_REQ'(1) << arb_j;
        win_data = DATA_WIDTH'(req_data >> (arb_j * DATA_WIDTH));
      end
    end
  end

  // Next-state and next-register values.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    abort_d = abort_q;
    grant_d = grant;
    din_d   = tx_din;
    unique case (state_q)
      IDLE: begin
        if (hit) begin
          state_d = START;
          idx_d   = win_idx;
          grant_d = win_oh;
          din_d   = win_data;
        end
      end
      START: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        // A tick on the threshold cycle still counts as success.
        if (tx_done_tick) begin
          state_d = ACK;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d = ACK;
          abort_d = 1'b1;
        end else if (cnt_q != {CW{1'b1}}) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ACK: begin
        state_d = IDLE;
        grant_d = '0;
        abort_d = 1'b0;
        rr_d    = (idx_q == PW'(N_REQ - 1)) ? '0 : idx_q + PW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      abort_q     <= 1'b0;
      grant       <= '0;
      tx_din      <= '0;
      tx_start    <= 1'b0;
      busy        <= 1'b0;
      ack         <= '0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      abort_q     <= abort_d;
      grant       <= grant_d;
      tx_din      <= din_d;
      tx_start    <= (state_d == START);
      busy        <= (state_d != IDLE);
      ack         <= (state_d == ACK) ? grant_d : '0;
      timeout_err <= (state_d == ACK) && abort_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: transaction table plus hand sequences for
// timeout, reset and stray-tick corners. A second instance uses a short timeout.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [3:0]  req_to = '0;
  logic [31:0] req_data = 32'hC35A3CA5;
  logic        tick = 1'b0;

  logic [3:0]  ack, grant;
  logic        busy, timeout_err, tx_start;
  logic [7:0]  tx_din;
  logic [3:0]  to_ack, to_grant;
  logic        to_busy, to_timeout_err, to_tx_start;
  logic [7:0]  to_tx_din;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
    .ack(ack), .grant(grant), .busy(busy), .timeout_err(timeout_err),
    .tx_start(tx_start), .tx_din(tx_din), .tx_done_tick(tick)
  );

  uart_tx_arbiter #(.TIMEOUT_CYCLES(16)) u_to (
    .clk(clk), .rst_n(rst_n), .req(req_to), .req_data(req_data),
    .ack(to_ack), .grant(to_grant), .busy(to_busy), .timeout_err(to_timeout_err),
    .tx_start(to_tx_start), .tx_din(to_tx_din), .tx_done_tick(tick)
  );

  typedef struct {
    logic       rst_before;
    logic [3:0] req_or;
    logic [3:0] exp_grant;
    logic [7:0] exp_din;
    int         wait_n;
    logic [3:0] rel_mask;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string nm);
    rst_n  = 1'b0;
    req    = '0;
    req_to = '0;
    tick   = 1'b0;
    #1;
    chk({nm, "_ack"}, 32'(ack), 0);
    chk({nm, "_grant"}, 32'(grant), 0);
    chk({nm, "_busy"}, 32'(busy), 0);
    chk({nm, "_terr"}, 32'(timeout_err), 0);
    chk({nm, "_start"}, 32'(tx_start), 0);
    chk({nm, "_din"}, 32'(tx_din), 0);
    step();
    step();
    chk({nm, "_held_busy"}, 32'(busy), 0);
    rst_n = 1'b1;
  endtask

  // One complete transfer on u_dut, starting in an IDLE cycle.
  task automatic txn(input string nm, input vec_t v);
    req = req | v.req_or;
    step();
    chk({nm, "_tx_start"}, 32'(tx_start), 1);
    chk({nm, "_grant"}, 32'(grant), 32'(v.exp_grant));
    chk({nm, "_tx_din"}, 32'(tx_din), 32'(v.exp_din));
    chk({nm, "_busy"}, 32'(busy), 1);
    chk({nm, "_ack_early"}, 32'(ack), 0);
    step();
    chk({nm, "_start_1cyc"}, 32'(tx_start), 0);
    for (int i = 1; i < v.wait_n; i++) step();
    chk({nm, "_no_ack_wait"}, 32'(ack), 0);
    tick = 1'b1;
    step();
    tick = 1'b0;
    chk({nm, "_ack"}, 32'(ack), 32'(v.exp_grant));
    chk({nm, "_terr"}, 32'(timeout_err), 0);
    req = req & ~v.rel_mask;
    step();
    chk({nm, "_idle_busy"}, 32'(busy), 0);
    chk({nm, "_idle_grant"}, 32'(grant), 0);
    chk({nm, "_idle_ack"}, 32'(ack), 0);
  endtask

  initial begin
    vec_t v;
    logic seen;
    int   n;

    vecs[0] = '{1'b0, 4'b0001, 4'b0001, 8'hA5, 20, 4'b0001};
    vecs[1] = '{1'b1, 4'b1111, 4'b0001, 8'hA5, 3,  4'b0001};
    vecs[2] = '{1'b0, 4'b0000, 4'b0010, 8'h3C, 1,  4'b0010};
    vecs[3] = '{1'b0, 4'b0000, 4'b0100, 8'h5A, 5,  4'b0100};
    vecs[4] = '{1'b0, 4'b0000, 4'b1000, 8'hC3, 2,  4'b1000};
    vecs[5] = '{1'b0, 4'b1111, 4'b0001, 8'hA5, 2,  4'b0000};
    vecs[6] = '{1'b0, 4'b0000, 4'b0010, 8'h3C, 4,  4'b0000};
    vecs[7] = '{1'b0, 4'b0000, 4'b0100, 8'h5A, 1,  4'b0000};
    vecs[8] = '{1'b0, 4'b0000, 4'b1000, 8'hC3, 3,  4'b0000};
    vecs[9] = '{1'b0, 4'b0000, 4'b0001, 8'hA5, 2,  4'b1111};

    do_reset("reset");

    // Stray tick while idle must do nothing.
    tick = 1'b1;
    step();
    tick = 1'b0;
    chk("stray_ack", 32'(ack), 0);
    chk("stray_busy", 32'(busy), 0);
    chk("stray_start", 32'(tx_start), 0);
    step();
    chk("stray_busy2", 32'(busy), 0);

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].rst_before) do_reset($sformatf("vreset%0d", i));
      txn($sformatf("vec%0d", i), vecs[i]);
    end

    // Requester 0 drops req and its byte changes mid-transfer; ack still arrives.
    req = 4'b0001;
    step();
    chk("drop_start", 32'(tx_start), 1);
    step();
    req      = 4'b0000;
    req_data = 32'hC35A3CFF;
    step();
    chk("drop_grant", 32'(grant), 32'h1);
    chk("drop_din", 32'(tx_din), 32'hA5);
    chk("drop_busy", 32'(busy), 1);
    tick = 1'b1;
    step();
    tick     = 1'b0;
    req_data = 32'hC35A3CA5;
    chk("drop_ack", 32'(ack), 32'h1);
    step();
    chk("drop_idle", 32'(busy), 0);

    // Short-timeout instance: no tick means abort 17 cycles after tx_start.
    req_to = 4'b0001;
    step();
    chk("to_start", 32'(to_tx_start), 1);
    req_to = 4'b0000;
    seen = 1'b0;
    n = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      n++;
      if (to_ack != 4'b0000) seen = 1'b1;
    end
    chk("to_seen", 32'(seen), 1);
    chk("to_latency", 32'(n), 17);
    chk("to_ack", 32'(to_ack), 32'h1);
    chk("to_terr", 32'(to_timeout_err), 1);
    step();
    chk("to_idle", 32'(to_busy), 0);
    chk("to_terr_pulse", 32'(to_timeout_err), 0);

    // Tick arriving on the threshold cycle is a success.
    req_to = 4'b0010;
    step();
    chk("thr_start", 32'(to_tx_start), 1);
    chk("thr_grant", 32'(to_grant), 32'h2);
    req_to = 4'b0000;
    step();
    repeat (15) step();
    tick = 1'b1;
    step();
    tick = 1'b0;
    chk("thr_ack", 32'(to_ack), 32'h2);
    chk("thr_terr", 32'(to_timeout_err), 0);
    step();
    chk("thr_idle", 32'(to_busy), 0);

    // Reset during WAIT abandons the transfer; arbitration restarts cleanly.
    req = 4'b0001;
    step();
    step();
    step();
    chk("midrst_busy_pre", 32'(busy), 1);
    do_reset("midrst");
    v = '{1'b0, 4'b0100, 4'b0100, 8'h5A, 4, 4'b0100};
    txn("post_rst", v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters, range 2..8.
REQ-002 Parameter DATA_WIDTH, default 8: byte width.
REQ-003 Parameter TIMEOUT_CYCLES, default 65535: maximum clk cycles in WAIT before abort.
REQ-004 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 req  input  N_REQ  per-requester transmit request, level.
REQ-007 req_data  input  N_REQ*DATA_WIDTH  requester i byte at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 ack  output  N_REQ  one-cycle pulse: requester byte finished or aborted.
REQ-009 grant  output  N_REQ  one-hot current owner; zero when idle.
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 timeout_err  output  1  one-cycle pulse coincident with an aborting ack.
REQ-012 tx_start  output  1  one-cycle start pulse to the shared uart_tx.
REQ-013 tx_din  output  DATA_WIDTH  byte to uart_tx; stable from tx_start until ack.
REQ-014 tx_done_tick  input  1  one-cycle pulse from uart_tx at the end of its stop bit.

Function
REQ-015 The FSM SHALL have the states IDLE, START, WAIT and ACK, all registered.
REQ-016 IDLE: if req is nonzero, the first set bit searching upward from rr_ptr with wraparound SHALL win, and the FSM SHALL go to START.
REQ-017 On the IDLE->START transition, the winner's byte SHALL be latched into tx_din and the one-hot winner into grant.
REQ-018 IDLE: if req is zero, the FSM SHALL stay in IDLE with all outputs zero apart from tx_din, which holds its last value.
REQ-019 START: tx_start=1 for exactly one cycle; next state WAIT; the timeout counter SHALL clear.
REQ-020 WAIT: on tx_done_tick=1, next state ACK.
REQ-021 WAIT: otherwise the counter SHALL increment each cycle.
REQ-022 WAIT: when the counter reaches TIMEOUT_CYCLES-1 without tx_done_tick, next state ACK with the abort flag set.
REQ-023 ACK: ack bit of the grant index = 1 for one cycle; timeout_err = abort flag.
REQ-024 ACK: rr_ptr SHALL be set to (grant index + 1) mod N_REQ, and the FSM SHALL return to IDLE, clearing grant and the abort flag on exit.
REQ-025 Latency: req sampled high in IDLE at edge k -> tx_start high during cycle k+1.
REQ-026 Latency: tx_done_tick at edge m -> ack high during cycle m+1.
REQ-027 Minimum spacing between consecutive tx_start pulses SHALL be 3 cycles plus the uart_tx frame time.
REQ-028 tx_done_tick in IDLE, START or ACK SHALL be ignored.
REQ-029 A req change after latch SHALL NOT alter grant, tx_din or the in-flight transfer; a dropped req still receives its ack.
REQ-030 req_data SHALL be sampled only on the IDLE->START edge.
REQ-031 A requester holding req high after ack SHALL be re-eligible in the following IDLE cycle with rotated priority; no requester waits more than N_REQ-1 transfers.
REQ-032 A tx_done_tick coinciding with the timeout threshold SHALL be treated as success (timeout_err=0).
REQ-033 The timeout counter SHALL be wide enough for TIMEOUT_CYCLES and SHALL saturate, never wrap.

Reset
REQ-034 While rst_n=0, regardless of clk, the following SHALL hold:
- FSM=IDLE, rr_ptr=0, abort flag=0, counter=0
- ack=0, grant=0, busy=0, timeout_err=0, tx_start=0, tx_din=0
REQ-035 Reset asserted mid-transfer SHALL abandon it without ack.
REQ-036 Arbitration SHALL resume from requester 0 on the first clk edge after release.

Verification
REQ-037 req=0001, data0=0xA5, tx_done_tick after 20 cycles in WAIT -> tx_start one cycle after req seen, tx_din=0xA5, grant=0001, ack=0001 one cycle after the tick, busy low afterwards.
REQ-038 req=1111 held, each released after its ack -> service order 0,1,2,3, each with its own byte.
REQ-039 req=1111 held continuously -> service order 0,1,2,3,0; no requester served twice in a row.
REQ-040 TIMEOUT_CYCLES=16, no tx_done_tick -> ack and timeout_err pulse together 17 cycles after tx_start, FSM returns to IDLE.
REQ-041 Stray tx_done_tick in IDLE -> no ack, no state change.
REQ-042 req0 dropped during WAIT -> ack0 still issued after the tick.
REQ-043 rst_n pulsed low during WAIT -> all outputs 0 immediately; next req=0100 gets grant=0100 without any stale ack.
